// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial line, counter status, checker results
// and the enables/strobes produced by the UART RX control FSM.
interface uart_rx_fsm_if;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       edge_bit_en;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;

  modport master (
    output RX_IN, PAR_EN, Prescale,
    output edge_cnt, bit_cnt,
    output strt_glitch, par_err, stp_err,
    input  edge_bit_en, dat_samp_en,
    input  deser_en, strt_chk_en,
    input  par_chk_en, stp_chk_en,
    input  data_valid
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale,
    input  edge_cnt, bit_cnt,
    input  strt_glitch, par_err, stp_err,
    output edge_bit_en, dat_samp_en,
    output deser_en, strt_chk_en,
    output par_chk_en, stp_chk_en,
    output data_valid
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART RX frame walker (start/data/parity/stop)
// driving sampler, deserializer and checker enables.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_fsm_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       frame_err;
  logic       frame_err_nxt;
  logic       cp;
  logic       last_bit;

  assign cp       = bus.edge_cnt == (bus.Prescale - 6'd1);
  assign last_bit = bus.bit_cnt == LAST_BIT;

  always_comb begin
    state_nxt     = state;
    frame_err_nxt = frame_err;
    unique case (state)
      IDLE: begin
        frame_err_nxt = 1'b0;
        if (!bus.RX_IN)
          state_nxt = START;
      end
      START: begin
        if (cp)
          state_nxt = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (cp && last_bit)
          state_nxt = bus.PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        // stop bit is always walked to keep bit alignment
        if (cp) begin
          if (bus.par_err)
            frame_err_nxt = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cp)
          state_nxt = (bus.stp_err || frame_err) ? IDLE : DONE;
      end
      DONE: begin
        state_nxt = bus.RX_IN ? IDLE : START;
      end
      default: begin
        state_nxt     = IDLE;
        frame_err_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  logic in_bit;

  assign in_bit = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);

  assign bus.edge_bit_en = in_bit;
  assign bus.dat_samp_en = in_bit;
  assign bus.strt_chk_en = state == START;
  assign bus.par_chk_en  = state == PARITY;
  assign bus.stp_chk_en  = state == STOP;
  assign bus.data_valid  = state == DONE;
  assign bus.deser_en    = (state == DATA) && cp;

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side control state machine for the UART RX path. It detects the falling edge of a start bit and enables the edge/bit counter, then walks the frame (start, data, optional parity, stop) using the counter's `edge_cnt`/`bit_cnt`. It drives the enables of the data sampler, deserializer and start/parity/stop checkers, and raises `data_valid` for one cycle when a frame is received without error.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK` input, 1 bit: the single clock; all state updates on its rising edge.
- `RST` input, 1 bit: reset, asynchronous and active-high.
- `RX_IN` input, 1 bit: serial line, idle high.
- `PAR_EN` input, 1 bit: 1 means a parity bit follows the data bits. Held static during a frame.
- `Prescale` input, 6 bits: clock cycles per bit. Legal values are 8, 16 and 32.
- `edge_cnt` input, 6 bits: from the edge/bit counter.
- `bit_cnt` input, 4 bits: from the edge/bit counter.
- `strt_glitch` input, 1 bit: start checker result, valid at the check point.
- `par_err` input, 1 bit: parity checker result, valid at the check point.
- `stp_err` input, 1 bit: stop checker result, valid at the check point.
- `edge_bit_en` output, 1 bit: enable to the edge/bit counter.
- `dat_samp_en` output, 1 bit: data sampler enable.
- `deser_en` output, 1 bit: shift strobe to the deserializer.
- `strt_chk_en` output, 1 bit: start checker enable.
- `par_chk_en` output, 1 bit: parity checker enable.
- `stp_chk_en` output, 1 bit: stop checker enable.
- `data_valid` output, 1 bit: one-cycle pulse marking a good frame.

## Operation
- **Check point (CP):** `edge_cnt == Prescale - 1`, computed 6 bits wide. All state transitions out of bit states happen only at CP.
- **States:** IDLE, START, DATA, PARITY, STOP, DONE.
- **Internal flag:** one 1-bit `frame_err` register.
- **IDLE:**
  - All outputs are 0. `frame_err` is cleared.
  - If `RX_IN == 0`, go to START.
- **START:**
  - At CP: if `strt_glitch == 1`, go to IDLE; otherwise go to DATA. `bit_cnt` becomes 1 on the same edge.
- **DATA:**
  - At CP with `bit_cnt == DATA_WIDTH`: go to PARITY if `PAR_EN == 1`, otherwise go to STOP.
- **PARITY:**
  - At CP: set `frame_err` if `par_err == 1`, then go to STOP.
  - The FSM always traverses the stop bit so that bit alignment is preserved.
- **STOP:**
  - At CP: if `stp_err == 1` or `frame_err == 1`, go to IDLE and do not assert `data_valid`.
  - Otherwise go to DONE.
- **DONE:**
  - Lasts exactly one cycle.
  - Next state is START if `RX_IN == 0` (back-to-back frame), otherwise IDLE.
- **Output decode** (registered state only, except `deser_en`):
  - `edge_bit_en` and `dat_samp_en` are 1 in START, DATA, PARITY and STOP.
  - `strt_chk_en` is 1 in START.
  - `par_chk_en` is 1 in PARITY.
  - `stp_chk_en` is 1 in STOP.
  - `data_valid` is 1 in DONE.
  - `deser_en = (state == DATA) && CP`: one pulse per data bit, exactly `DATA_WIDTH` pulses per frame.
- **Counter clearing:** `edge_bit_en` is 0 in IDLE and DONE, so the counter clears to 0 before every START entry.
- **Out-of-spec inputs:** checker flags outside their state's CP are ignored. `Prescale < 2` is unsupported and its behaviour is undefined.
- **Reset:** `RST` high at any time, including mid-frame, forces IDLE, clears `frame_err`, and drives every output to 0 immediately (asynchronously). The first START is possible on the first rising edge after `RST` falls.

## Timing
- **Start detection:** `RX_IN` sampled low at rising edge E0 puts the FSM in START from E0. Detection latency is one cycle.
- **Bit duration:** each bit state lasts exactly `Prescale` cycles. `edge_cnt` runs 0 to `Prescale-1` within each bit.
- **Frame length:** N = `(DATA_WIDTH + 2 + PAR_EN) * Prescale` cycles.
  - DONE is entered at edge E0 + N.
  - `data_valid` is high for one cycle from that edge.
- **`deser_en` pulse k** (k = 1..DATA_WIDTH) is high during the cycle ending at edge E0 + (k+1)*`Prescale`.
- **Start glitch:** return to IDLE at edge E0 + `Prescale`.
- **Back-to-back frames:** with `RX_IN == 0` during DONE, the next START is entered at E0 + N + 1, so the `data_valid` period is N + 1 cycles.
- **No stalls:** the FSM does not wait on any handshake; it has no backpressure.

## Test plan
- **Reset:** assert `RST` mid-DATA with `Prescale = 8` → all outputs 0 in the same cycle; the state is IDLE after release; a new frame then decodes correctly.
- **Clean frame, no parity:** `Prescale = 8`, `PAR_EN = 0`, frame 0xA5, all flags 0 → 8 `deser_en` pulses at E0+16, E0+24, … E0+72; `data_valid` is high for one cycle at E0+80.
- **Parity error:** `Prescale = 16`, `PAR_EN = 1`, `par_err = 1` at the parity CP → STOP is still traversed (`stp_chk_en` high for 16 cycles); no `data_valid`; IDLE at E0+176.
- **Start glitch:** `strt_glitch = 1` at the START CP → IDLE at E0+8, zero `deser_en` pulses, `edge_bit_en` low from E0+8.
- **Stop error:** `Prescale = 32`, `PAR_EN = 0`, `stp_err = 1` at the stop CP → no `data_valid`; IDLE at E0+320.
- **Back-to-back frames:** `Prescale = 8`, `PAR_EN = 0`, `RX_IN` held low during DONE → two `data_valid` pulses exactly 81 cycles apart; the IDLE state is never visited between them.
